// File: rtl/morse_pkg.sv
// Shared definitions for the Morse pattern player: symbol encodings,
// controller states and the unit counts used for marks and spaces.
package morse_pkg;

   // Two-bit symbol code carried in the pattern, MSB pair first.
   typedef enum logic [1:0] {
      SYM_GAP   = 2'b00,
      SYM_SHORT = 2'b01,
      SYM_LONG  = 2'b10,
      SYM_END   = 2'b11
   } sym_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_MARK  = 3'd2,
      ST_SPACE = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

   // Interval lengths in Morse units.
   localparam int                 UNITS_W     = 2;
   localparam logic [UNITS_W-1:0] UNITS_ONE   = 2'd1;
   localparam logic [UNITS_W-1:0] UNITS_THREE = 2'd3;

endpackage

// File: rtl/unit_timer.sv
// Unit prescaler: counts 'units' Morse units of 'period' cycles each and
// pulses 'expire' on the last cycle of the interval. Counters restart on
// expiry so back-to-back intervals need no extra clear cycle.
module unit_timer
   import morse_pkg::*;
#(
   parameter int CNT_W = 25
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic [CNT_W-1:0]   period,
   input  logic [UNITS_W-1:0] units,
   output logic               expire
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [UNITS_W-1:0] unit_q, unit_d;
   logic               unit_end;

   // Detect the last cycle of a unit and the last unit of the interval.
   always_comb begin
      unit_end = (cnt_q == period - CNT_ONE);
      expire   = !clear && unit_end && (unit_q == units - UNITS_ONE);
   end

   // Advance the cycle and unit counters, restarting on clear or expiry.
   always_comb begin
      cnt_d  = cnt_q + CNT_ONE;
      unit_d = unit_q;
      if (clear || expire) begin
         cnt_d  = '0;
         unit_d = '0;
      end else if (unit_end) begin
         cnt_d  = '0;
         unit_d = unit_q + UNITS_ONE;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         unit_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         unit_q <= unit_d;
      end
   end

endmodule

// File: rtl/morse_player.sv
// Morse pattern player: latches a string of 2-bit symbols and plays it out
// as timed marks and spaces, one symbol fetched per FETCH cycle.
module morse_player
   import morse_pkg::*;
#(
   parameter int PAT_W = 16,
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] period,
   output logic             tone,
   output logic             short_o,
   output logic             long_o,
   output logic             busy,
   output logic             done
);

   localparam int                NSYM      = PAT_W / 2;
   localparam int                SCNT_W    = $clog2(NSYM + 1);
   localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(NSYM);
   localparam logic [CNT_W-1:0]  P_MIN     = CNT_W'(1);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]   per_q, per_d;
   sym_e               sym_q, sym_d;
   logic [SCNT_W-1:0]  scnt_q, scnt_d;

   sym_e               top_sym;
   logic               launch;
   logic               timer_clear;
   logic               timer_expire;
   logic [UNITS_W-1:0] timer_units;

   // Decode the pending symbol, the launch condition and the timer setup.
   // The timer only runs in MARK/SPACE; everywhere else it is held clear so
   // each timed state starts from a zero prescaler.
   always_comb begin
      top_sym     = sym_e'(pat_q[PAT_W-1 -: 2]);
      launch      = (state_q == ST_IDLE) && start && !abort;
      timer_clear = !((state_q == ST_MARK) || (state_q == ST_SPACE));
      timer_units = UNITS_ONE;
      if (state_q == ST_MARK) begin
         timer_units = (sym_q == SYM_LONG) ? UNITS_THREE : UNITS_ONE;
      end else if (state_q == ST_SPACE) begin
         // A gap symbol is a word space; after a mark it is the element gap.
         timer_units = (sym_q == SYM_GAP) ? UNITS_THREE : UNITS_ONE;
      end
   end

   unit_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .period (per_q),
      .units  (timer_units),
      .expire (timer_expire)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort outranks every other transition.
   always_comb begin
      state_d = state_q;
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (launch) state_d = ST_FETCH;
            ST_FETCH: begin
               case (top_sym)
                  SYM_SHORT, SYM_LONG: state_d = ST_MARK;
                  SYM_GAP:             state_d = ST_SPACE;
                  default:             state_d = ST_FIN;
               endcase
            end
            ST_MARK:  if (timer_expire) state_d = ST_SPACE;
            ST_SPACE: begin
               if (timer_expire) begin
                  state_d = (scnt_q == SCNT_LAST) ? ST_FIN : ST_FETCH;
               end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Latch pattern and period at launch; consume one symbol per FETCH.
   always_comb begin
      pat_d  = pat_q;
      per_d  = per_q;
      sym_d  = sym_q;
      scnt_d = scnt_q;
      if (launch) begin
         pat_d  = pattern;
         per_d  = (period == '0) ? P_MIN : period;
         scnt_d = '0;
      end else if (state_q == ST_FETCH) begin
         pat_d  = pat_q << 2;
         sym_d  = top_sym;
         scnt_d = scnt_q + SCNT_ONE;
      end
   end

   // Playback datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q  <= '0;
         per_q  <= '0;
         sym_q  <= SYM_GAP;
         scnt_q <= '0;
      end else begin
         pat_q  <= pat_d;
         per_q  <= per_d;
         sym_q  <= sym_d;
         scnt_q <= scnt_d;
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      tone    = (state_q == ST_MARK);
      short_o = (state_q == ST_MARK) && (sym_q == SYM_SHORT);
      long_o  = (state_q == ST_MARK) && (sym_q == SYM_LONG);
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_FIN);
   end

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player (PAT_W=8). Each playback is recorded as a
// per-cycle string: '-' busy and silent, 'S' short mark, 'L' long mark,
// 'D' done, 'X' inconsistent mark outputs, 'T' cycle budget exhausted.
module tb_morse_player;

   localparam int PAT_W = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] period;
   logic             tone;
   logic             short_o;
   logic             long_o;
   logic             busy;
   logic             done;

   int n_vec = 0;
   int n_err = 0;

   morse_player #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .pattern (pattern),
      .period  (period),
      .tone    (tone),
      .short_o (short_o),
      .long_o  (long_o),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Drive a start request at the falling edge; the next rising edge launches.
   task automatic kick(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] per);
      @(negedge clk);
      pattern = pat;
      period  = per;
      start   = 1'b1;
   endtask

   // Record outputs each falling edge until busy drops. act_kind 1 rewrites
   // pattern/period, 2 raises abort, after sample number act_at.
   task automatic capture(input int maxc, input int act_at, input int act_kind,
                          input bit hold_start, output string tr);
      int k;
      k  = 0;
      tr = "";
      forever begin
         @(negedge clk);
         if (!busy) break;
         if (k >= maxc) begin
            tr = {tr, "T"};
            break;
         end
         if (tone && short_o && !long_o)      tr = {tr, "S"};
         else if (tone && long_o && !short_o) tr = {tr, "L"};
         else if (tone || short_o || long_o)  tr = {tr, "X"};
         else if (done)                       tr = {tr, "D"};
         else                                 tr = {tr, "-"};
         if (k == 0 && !hold_start) start = 1'b0;
         if (k == act_at) begin
            if (act_kind == 1) begin
               pattern = 8'hFF;
               period  = 8'd7;
            end else if (act_kind == 2) begin
               abort = 1'b1;
            end
         end
         k++;
      end
      abort = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      pattern = '0;
      period  = '0;
      repeat (2) @(negedge clk);
      n_vec++; if (tone !== 1'b0)    begin n_err++; $display("FAIL reset_tone: got %b want 0", tone); end
      n_vec++; if (short_o !== 1'b0) begin n_err++; $display("FAIL reset_short: got %b want 0", short_o); end
      n_vec++; if (long_o !== 1'b0)  begin n_err++; $display("FAIL reset_long: got %b want 0", long_o); end
      n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      string tr;
      kick(8'b01_10_00_11, 8'd2);
      capture(100, -1, 0, 1'b0, tr);
      n_vec++;
      if (tr != "-SS---LLLLLL----------D") begin
         n_err++; $display("FAIL basic_trace: got %s want -SS---LLLLLL----------D", tr);
      end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_after: got %b want 0", done); end
   endtask

   task automatic test_zero_period();
      string tr;
      kick(8'b01_01_01_01, 8'd0);
      capture(100, -1, 0, 1'b0, tr);
      n_vec++;
      if (tr != "-S--S--S--S-D") begin
         n_err++; $display("FAIL zero_period_trace: got %s want -S--S--S--S-D", tr);
      end
   endtask

   task automatic test_hold_start();
      string tr;
      kick(8'b10_11_00_00, 8'd1);
      capture(100, -1, 0, 1'b1, tr);
      n_vec++;
      if (tr != "-LLL--D") begin
         n_err++; $display("FAIL hold_start_trace: got %s want -LLL--D", tr);
      end
      // start still high: the player relaunches only now that it is idle.
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_start_relaunch: got busy %b want 1", busy); end
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_start_cleanup: got busy %b want 0", busy); end
   endtask

   task automatic test_abort();
      string tr;
      int pulses;
      kick(8'b10_01_00_11, 8'd2);
      capture(100, 2, 2, 1'b0, tr);
      n_vec++;
      if (tr != "-LL") begin
         n_err++; $display("FAIL abort_trace: got %s want -LL", tr);
      end
      n_vec++; if (tone !== 1'b0)   begin n_err++; $display("FAIL abort_tone: got %b want 0", tone); end
      n_vec++; if (long_o !== 1'b0) begin n_err++; $display("FAIL abort_long: got %b want 0", long_o); end
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d busy/done cycles want 0", pulses); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      pattern = 8'b01_11_00_00;
      period  = 8'd1;
      start   = 1'b1;
      abort   = 1'b1;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_abort_idle: got busy %b want 0", busy); end
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_abort_after: got busy %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      string tr;
      kick(8'b01_00_00_00, 8'd3);
      // FETCH, three short-mark cycles, then first cycle of the space.
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_vec++; if ({busy, tone} !== 2'b10) begin n_err++; $display("FAIL reset_mid_in_space: got busy,tone %b want 10", {busy, tone}); end
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if ({tone, short_o, long_o, busy, done} !== 5'b00000) begin
         n_err++; $display("FAIL reset_mid_async: got %b want 00000", {tone, short_o, long_o, busy, done});
      end
      @(negedge clk);
      reset = 1'b0;
      kick(8'b11_00_00_00, 8'd5);
      capture(100, -1, 0, 1'b0, tr);
      n_vec++;
      if (tr != "-D") begin
         n_err++; $display("FAIL reset_mid_restart: got %s want -D", tr);
      end
   endtask

   task automatic test_latched();
      string tr;
      kick(8'b01_10_00_11, 8'd2);
      capture(100, 1, 1, 1'b0, tr);
      n_vec++;
      if (tr != "-SS---LLLLLL----------D") begin
         n_err++; $display("FAIL latched_trace: got %s want -SS---LLLLLL----------D", tr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_period();
      test_hold_start();
      test_abort();
      test_start_abort_idle();
      test_reset_mid();
      test_latched();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
